// File: rtl/gfx_pattern_pkg.sv
// Shared pattern-select codes, FSM state type and constants for the gfx_pattern_gen block.
// The `GFX_PAT_* macros carry the mode encodings so every file decodes mode_q identically.
`ifndef GFX_PATTERN_DEFS_VH
`define GFX_PATTERN_DEFS_VH
`define GFX_PAT_BARS     2'd0
`define GFX_PAT_CHECKER  2'd1
`define GFX_PAT_GRADIENT 2'd2
`define GFX_PAT_BORDER   2'd3
`endif

package gfx_pattern_pkg;

    localparam int RGB_CHANNELS = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } gen_state_e;

endpackage

// File: rtl/gfx_pattern_color.sv
// Combinational pattern colour: maps (mode_q, pattern x, raster x, y) to an R|G|B pixel.
// BORDER keys off the raw raster x so it never scrolls; the other modes use px.
module gfx_pattern_color
    import gfx_pattern_pkg::*;
#(
    parameter int FB_WIDTH    = 640,
    parameter int FB_HEIGHT   = 480,
    parameter int PIXEL_BITS  = 12,
    parameter int BAR_COUNT   = 8,
    parameter int CHECK_SHIFT = 3,
    localparam int FB_X_BITS  = $clog2(FB_WIDTH),
    localparam int FB_Y_BITS  = $clog2(FB_HEIGHT)
) (
    input  logic [1:0]            mode_q,
    input  logic [FB_X_BITS-1:0]  px,
    input  logic [FB_X_BITS-1:0]  x,
    input  logic [FB_Y_BITS-1:0]  y,
    output logic [PIXEL_BITS-1:0] color
);

    localparam int COLOR_BITS = PIXEL_BITS / RGB_CHANNELS;
    localparam logic [31:0] BAR_W = 32'(FB_WIDTH / BAR_COUNT);
    localparam logic [FB_X_BITS-1:0] MAX_X = FB_X_BITS'(FB_WIDTH - 1);
    localparam logic [FB_Y_BITS-1:0] MAX_Y = FB_Y_BITS'(FB_HEIGHT - 1);

    logic [31:0]           px_wide;
    logic [31:0]           y_wide;
    logic [31:0]           bar_idx;
    logic [COLOR_BITS-1:0] grad;
    logic [PIXEL_BITS-1:0] bar_rgb;
    logic [PIXEL_BITS-1:0] grad_rgb;
    logic                  chk_on;
    logic                  brd_on;
    logic                  unused_bits;

    // Widen before indexing so small frames never index past the vector end.
    assign px_wide = 32'(px);
    assign y_wide  = 32'(y);
    assign bar_idx = px_wide / BAR_W;
    assign chk_on  = px_wide[CHECK_SHIFT] ^ y_wide[CHECK_SHIFT];
    assign brd_on  = (x == '0) || (x == MAX_X) || (y == '0) || (y == MAX_Y);
    assign grad    = px[FB_X_BITS-1 -: COLOR_BITS];

    // Channel gi=0 is blue (LSBs); bar index bit gi drives that channel.
    generate
        for (genvar gi = 0; gi < RGB_CHANNELS; gi++) begin : g_chan
            assign bar_rgb[gi*COLOR_BITS +: COLOR_BITS]  = {COLOR_BITS{bar_idx[gi]}};
            assign grad_rgb[gi*COLOR_BITS +: COLOR_BITS] = grad;
        end
    endgenerate

    assign unused_bits = ^{bar_idx, px_wide, y_wide};

    always_comb begin
        color = '0;
        case (mode_q)
            `GFX_PAT_BARS:     color = bar_rgb;
            `GFX_PAT_CHECKER:  color = {PIXEL_BITS{chk_on}};
            `GFX_PAT_GRADIENT: color = grad_rgb;
            default:           color = {PIXEL_BITS{brd_on}};
        endcase
    end

endmodule

// File: rtl/gfx_pattern_gen.sv
// Raster-order test-pattern source with valid/ready backpressure and latched per-frame mode.
// Optional feature: define GFX_PATTERN_ANIMATE_EN to scroll modes 0-2 by one pixel per frame.
module gfx_pattern_gen
    import gfx_pattern_pkg::*;
#(
    parameter int FB_WIDTH    = 640,
    parameter int FB_HEIGHT   = 480,
    parameter int PIXEL_BITS  = 12,
    parameter int BAR_COUNT   = 8,
    parameter int CHECK_SHIFT = 3,
    localparam int FB_X_BITS  = $clog2(FB_WIDTH),
    localparam int FB_Y_BITS  = $clog2(FB_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic                  ready,
    output logic [FB_X_BITS-1:0]  x,
    output logic [FB_Y_BITS-1:0]  y,
    output logic [PIXEL_BITS-1:0] color,
    output logic                  valid,
    output logic                  last_x,
    output logic                  last
);

    localparam logic [FB_X_BITS-1:0] MAX_X = FB_X_BITS'(FB_WIDTH - 1);
    localparam logic [FB_Y_BITS-1:0] MAX_Y = FB_Y_BITS'(FB_HEIGHT - 1);

    gen_state_e            state_reg;
    logic [FB_X_BITS-1:0]  x_reg;
    logic [FB_Y_BITS-1:0]  y_reg;
    logic [PIXEL_BITS-1:0] color_reg;
    logic                  valid_reg;
    logic                  last_x_reg;
    logic                  last_reg;
    logic [1:0]            mode_reg;
    // Position of the next pixel to issue; survives idle gaps so a resumed stream continues.
    logic [FB_X_BITS-1:0]  nx_reg;
    logic [FB_Y_BITS-1:0]  ny_reg;

    logic                  advance;
    logic                  accept;
    logic                  at_origin;
    logic                  nx_last;
    logic                  ny_last;
    logic [1:0]            mode_next;
    logic [FB_X_BITS-1:0]  px;
    logic [PIXEL_BITS-1:0] color_next;

    assign advance   = enable & (~valid_reg | ready);
    assign accept    = valid_reg & ready;
    assign at_origin = (nx_reg == '0) && (ny_reg == '0);
    assign nx_last   = (nx_reg == MAX_X);
    assign ny_last   = (ny_reg == MAX_Y);
    // The origin pixel already uses the freshly latched mode.
    assign mode_next = at_origin ? mode : mode_reg;

`ifdef GFX_PATTERN_ANIMATE_EN
    localparam logic [FB_X_BITS:0] PX_WRAP = (FB_X_BITS + 1)'(FB_WIDTH);

    logic [FB_X_BITS-1:0] off_reg;
    logic [FB_X_BITS-1:0] off_next;
    logic [FB_X_BITS-1:0] off_eff;
    logic [FB_X_BITS:0]   px_sum;

    assign off_next = (off_reg == MAX_X) ? '0 : off_reg + 1'b1;
    // The next frame's (0,0) can issue on the same edge that accepts last.
    assign off_eff  = (accept && last_reg) ? off_next : off_reg;
    assign px_sum   = {1'b0, nx_reg} + {1'b0, off_eff};
    assign px       = (px_sum >= PX_WRAP) ? FB_X_BITS'(px_sum - PX_WRAP) : px_sum[FB_X_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            off_reg <= '0;
        end else if (accept && last_reg) begin
            off_reg <= off_next;
        end
    end
`else
    assign px = nx_reg;
`endif

    gfx_pattern_color #(
        .FB_WIDTH    (FB_WIDTH),
        .FB_HEIGHT   (FB_HEIGHT),
        .PIXEL_BITS  (PIXEL_BITS),
        .BAR_COUNT   (BAR_COUNT),
        .CHECK_SHIFT (CHECK_SHIFT)
    ) u_color (
        .mode_q (mode_next),
        .px     (px),
        .x      (nx_reg),
        .y      (ny_reg),
        .color  (color_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            valid_reg  <= 1'b0;
            x_reg      <= '0;
            y_reg      <= '0;
            color_reg  <= '0;
            last_x_reg <= 1'b0;
            last_reg   <= 1'b0;
            mode_reg   <= '0;
            nx_reg     <= '0;
            ny_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (advance) begin
                        state_reg <= ST_ACTIVE;
                        valid_reg <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!advance && accept) begin
                        state_reg <= ST_IDLE;
                        valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    valid_reg <= 1'b0;
                end
            endcase

            if (advance) begin
                x_reg      <= nx_reg;
                y_reg      <= ny_reg;
                color_reg  <= color_next;
                last_x_reg <= nx_last;
                last_reg   <= nx_last & ny_last;
                if (at_origin) begin
                    mode_reg <= mode;
                end
                if (nx_last) begin
                    nx_reg <= '0;
                    ny_reg <= ny_last ? '0 : ny_reg + 1'b1;
                end else begin
                    nx_reg <= nx_reg + 1'b1;
                end
            end
        end
    end

    assign x      = x_reg;
    assign y      = y_reg;
    assign color  = color_reg;
    assign valid  = valid_reg;
    assign last_x = last_x_reg;
    assign last   = last_reg;

endmodule

// File: tb/tb_gfx_pattern_gen.sv
// Directed bench for gfx_pattern_gen on a 16x4 frame: raster order, all four modes,
// backpressure, mode switch mid-frame, enable drop, mid-frame reset (and scrolling when enabled).
module tb_gfx_pattern_gen;

    localparam int W  = 16;
    localparam int H  = 4;
    localparam int PB = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [1:0]    mode;
    logic          ready;
    logic [3:0]    x;
    logic [1:0]    y;
    logic [PB-1:0] color;
    logic          valid;
    logic          last_x;
    logic          last;

    int total = 0;
    int bad   = 0;
    int cur_mode = 0;
    int off_m = 0;

    always #5 clk = ~clk;

    gfx_pattern_gen #(
        .FB_WIDTH    (W),
        .FB_HEIGHT   (H),
        .PIXEL_BITS  (PB),
        .BAR_COUNT   (8),
        .CHECK_SHIFT (1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .mode   (mode),
        .ready  (ready),
        .x      (x),
        .y      (y),
        .color  (color),
        .valid  (valid),
        .last_x (last_x),
        .last   (last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference colour for a 16-wide frame, bar width 2, checker cell 2.
    function automatic logic [11:0] model(input int m, input int rx, input int ry, input int off);
        int px;
        int b;
        logic [3:0] n;
        px = (rx + off) % W;
        b  = px / 2;
        n  = 4'(px);
        case (m)
            0: model = {(((b >> 2) & 1) != 0) ? 4'hF : 4'h0,
                        (((b >> 1) & 1) != 0) ? 4'hF : 4'h0,
                        ((b & 1) != 0) ? 4'hF : 4'h0};
            1: model = ((((px >> 1) ^ (ry >> 1)) & 1) != 0) ? 12'hFFF : 12'h000;
            2: model = {n, n, n};
            default: model = (rx == 0 || rx == W - 1 || ry == 0 || ry == H - 1) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    // One clock; tracks which mode / scroll offset the next frame will carry.
    task automatic step();
        if (valid && ready && last) begin
`ifdef GFX_PATTERN_ANIMATE_EN
            off_m = (off_m + 1) % W;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_pixel(input int p);
        int ex;
        int ey;
        ex = p % W;
        ey = p / W;
        if (p == 0) cur_mode = int'(mode);
        chk("valid", valid, 1);
        chk("x", x, ex);
        chk("y", y, ey);
        chk("last_x", last_x, ex == W - 1);
        chk("last", last, p == W * H - 1);
        chk("color", color, model(cur_mode, ex, ey, off_m));
        if (off_m == 0) begin
            if (cur_mode == 0 && ey == 0 && (ex == 0 || ex == 1)) chk("bars_lo", color, 12'h000);
            if (cur_mode == 0 && ey == 0 && (ex == 2 || ex == 3)) chk("bars_blue", color, 12'h00F);
            if (cur_mode == 0 && ey == 0 && ex >= 14) chk("bars_white", color, 12'hFFF);
            if (cur_mode == 1 && ex == 0 && ey == 0) chk("chk_00", color, 12'h000);
            if (cur_mode == 1 && ex == 2 && ey == 0) chk("chk_20", color, 12'hFFF);
            if (cur_mode == 1 && ex == 2 && ey == 2) chk("chk_22", color, 12'h000);
            if (cur_mode == 2 && ex == 15) chk("grad_15", color, 12'hFFF);
            if (cur_mode == 2 && ex == 8) chk("grad_8", color, 12'h888);
        end
        if (cur_mode == 3 && ((ex == 5 && ey == 0) || (ex == 0 && ey == 2) || (ex == 15 && ey == 1)))
            chk("border_on", color, 12'hFFF);
        if (cur_mode == 3 && ex == 5 && ey == 2) chk("border_off", color, 12'h000);
`ifdef GFX_PATTERN_ANIMATE_EN
        if (cur_mode == 0 && off_m == 1 && ey == 0 && ex < 2)
            chk("anim_scroll", color, (ex == 0) ? 12'h000 : 12'h00F);
`endif
    endtask

    initial begin
        int p;
        int cyc;
        reset  = 1'b1;
        enable = 1'b0;
        ready  = 1'b0;
        mode   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_color", color, 0);
        chk("rst_last", last, 0);
        chk("rst_last_x", last_x, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_no_enable", valid, 0);
        end

        // Four back-to-back frames: modes 0,1,2,3, then mode 0 queued for the next.
        enable = 1'b1;
        ready  = 1'b1;
        step();
        for (int f = 0; f < 4; f++) begin
            for (int q = 0; q < W * H; q++) begin
                check_pixel(q);
                if (q == W * H - 1) mode = 2'((f + 1) % 4);
                step();
            end
        end
        $display("frames 0-3 streamed: total=%0d", total);

        // Random backpressure; mode change at (7,1) must not affect this frame.
        p = 0;
        cyc = 0;
        while (p < W * H && cyc < 400) begin
            check_pixel(p);
            if (p == 23) mode = 2'd1;
            if ($urandom_range(0, 2) == 0) begin
                ready  = 1'b0;
                enable = 1'($urandom_range(0, 1));
            end else begin
                ready  = 1'b1;
                enable = 1'b1;
            end
            if (ready) p++;
            step();
            cyc++;
        end
        chk("stall_budget", p, W * H);
        ready  = 1'b1;
        enable = 1'b1;
        $display("stall frame done in %0d cycles", cyc);

        // Enable dropped after (5,0); resume at (6,0).
        for (int q = 0; q < W * H; q++) begin
            check_pixel(q);
            if (q == 5) begin
                enable = 1'b0;
                step();
                chk("drop_valid", valid, 0);
                step();
                chk("drop_hold", valid, 0);
                enable = 1'b1;
            end
            step();
        end
        $display("enable-drop frame done: total=%0d", total);

        // Reset at (9,2), restart with BORDER.
        for (int q = 0; q < W * H; q++) begin
            check_pixel(q);
            if (q == 9 + 2 * W) begin
                reset = 1'b1;
                step();
                chk("mid_rst_valid", valid, 0);
                chk("mid_rst_x", x, 0);
                chk("mid_rst_y", y, 0);
                chk("mid_rst_color", color, 0);
                chk("mid_rst_last", last, 0);
                reset = 1'b0;
                mode  = 2'd3;
                off_m = 0;
                break;
            end
            step();
        end
        step();
        for (int q = 0; q < W * H; q++) begin
            check_pixel(q);
            if (q == W * H - 1) mode = 2'd0;
            step();
        end
        for (int q = 0; q < W * H; q++) begin
            check_pixel(q);
            step();
        end
        $display("restart frames done: total=%0d", total);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
